// File: rtl/divider_seq_ctrl.sv
// divider_seq_ctrl: sequential restoring divider, one quotient bit per ITER cycle.
// Optional two's-complement mode is built in when DIVIDER_SIGNED_EN is defined.
// It adds the signed_op port, operand magnitude conversion and a result sign fix-up.
// Result registers change only when an operation completes. The working registers
// hold the intermediate state, so partial results never reach the outputs.
module divider_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef DIVIDER_SIGNED_EN
  input  logic             signed_op,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CHECK, ITER, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   dvd;
  logic [WIDTH-1:0]   dsr;
  logic [WIDTH-1:0]   q_sh;
  logic [WIDTH:0]     r_part;
  logic [CNT_W-1:0]   cnt;
  logic               dsr_zero;
  logic [WIDTH:0]     r_shift;
  logic               r_ge;
  logic [WIDTH:0]     r_next;
  logic [WIDTH-1:0]   q_next;
  logic [WIDTH-1:0]   q_final;
  logic [WIDTH-1:0]   r_final;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + 1'b1;
  endfunction

`ifdef DIVIDER_SIGNED_EN
  logic signed_lat;
  logic neg_q;
  logic neg_r;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic use_sign);
    return (use_sign && v[WIDTH-1]) ? negate(v) : v;
  endfunction
`endif

  assign dsr_zero = (dsr == '0);

  // One restoring step. R stays below the divisor after every step, so the
  // top bit of R dropped by the truncation below is always zero.
  always_comb begin
    r_shift = (WIDTH+1)'({r_part, dvd[WIDTH-1]});
    r_ge    = (r_shift >= {1'b0, dsr});
    r_next  = r_ge ? (r_shift - {1'b0, dsr}) : r_shift;
    q_next  = {q_sh[WIDTH-2:0], r_ge};
`ifdef DIVIDER_SIGNED_EN
    q_final = neg_q ? negate(q_next) : q_next;
    r_final = neg_r ? negate(WIDTH'(r_next)) : WIDTH'(r_next);
`else
    q_final = q_next;
    r_final = WIDTH'(r_next);
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and status decode
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = CHECK;
      CHECK: begin
        busy      = 1'b1;
        state_nxt = dsr_zero ? DONE : ITER;
      end
      ITER: begin
        busy = 1'b1;
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd       <= '0;
      dsr       <= '0;
      q_sh      <= '0;
      r_part    <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      signed_lat <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          dvd <= dividend;
          dsr <= divisor;
`ifdef DIVIDER_SIGNED_EN
          signed_lat <= signed_op;
`endif
        end
        CHECK: begin
          if (dsr_zero) begin
            quotient  <= '1;
            remainder <= dvd;
            div_zero  <= 1'b1;
          end else begin
            r_part <= '0;
            q_sh   <= '0;
            cnt    <= CNT_W'(WIDTH - 1);
`ifdef DIVIDER_SIGNED_EN
            dvd   <= magnitude(dvd, signed_lat);
            dsr   <= magnitude(dsr, signed_lat);
            neg_q <= signed_lat && (dvd[WIDTH-1] ^ dsr[WIDTH-1]);
            neg_r <= signed_lat && dvd[WIDTH-1];
`endif
          end
        end
        ITER: begin
          r_part <= r_next;
          q_sh   <= q_next;
          dvd    <= {dvd[WIDTH-2:0], 1'b0};
          if (cnt == '0) begin
            quotient  <= q_final;
            remainder <= r_final;
            div_zero  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_seq_ctrl.sv
// Directed bench for divider_seq_ctrl at WIDTH=32.
// Cycle n is the clock period after rising edge n-1, where edge 0 accepts start.
// Signals are sampled on falling edges.
module tb_divider_seq_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         signed_op;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  int checks   = 0;
  int failures = 0;

  divider_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
`ifdef DIVIDER_SIGNED_EN
    .signed_op (signed_op),
`endif
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic launch(input logic [W-1:0] dd, input logic [W-1:0] ds, input logic sop);
    @(negedge clk);
    start     = 1'b1;
    dividend  = dd;
    divisor   = ds;
    signed_op = sop;
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0; dividend = '0; divisor = '0; signed_op = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (quotient !== '0) begin failures++; $display("FAIL reset_q got=%h exp=0", quotient); end
    checks++; if (remainder !== '0) begin failures++; $display("FAIL reset_r got=%h exp=0", remainder); end
    checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL reset_dz got=%b exp=0", div_zero); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    launch(32'd100, 32'd7, 1'b0);
    for (int n = 1; n <= 36; n++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== (n <= 33)) begin failures++; $display("FAIL basic_busy cyc=%0d got=%b exp=%b", n, busy, (n <= 33)); end
      checks++;
      if (done !== (n == 34)) begin failures++; $display("FAIL basic_done cyc=%0d got=%b exp=%b", n, done, (n == 34)); end
      if (n == 20) begin
        checks++;
        if (quotient !== '0) begin failures++; $display("FAIL basic_q_hidden got=%h exp=0", quotient); end
      end
      if (n == 34) begin
        checks++; if (quotient !== 32'd14) begin failures++; $display("FAIL basic_q got=%h exp=%h", quotient, 32'd14); end
        checks++; if (remainder !== 32'd2) begin failures++; $display("FAIL basic_r got=%h exp=%h", remainder, 32'd2); end
        checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL basic_dz got=%b exp=0", div_zero); end
      end
    end
  endtask

  task automatic test_div_zero;
    int cyc;
    launch(32'd5, 32'd0, 1'b0);
    wait_done(cyc);
    checks++; if (cyc != 2) begin failures++; $display("FAIL dz_latency got=%0d exp=2", cyc); end
    checks++; if (quotient !== 32'hFFFFFFFF) begin failures++; $display("FAIL dz_q got=%h exp=ffffffff", quotient); end
    checks++; if (remainder !== 32'd5) begin failures++; $display("FAIL dz_r got=%h exp=5", remainder); end
    checks++; if (div_zero !== 1'b1) begin failures++; $display("FAIL dz_flag got=%b exp=1", div_zero); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL dz_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_extremes;
    int cyc;
    launch(32'hFFFFFFFF, 32'd1, 1'b0);
    wait_done(cyc);
    checks++; if (cyc != 34) begin failures++; $display("FAIL ext1_latency got=%0d exp=34", cyc); end
    checks++; if (quotient !== 32'hFFFFFFFF) begin failures++; $display("FAIL ext1_q got=%h exp=ffffffff", quotient); end
    checks++; if (remainder !== 32'd0) begin failures++; $display("FAIL ext1_r got=%h exp=0", remainder); end
    checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL ext1_dz got=%b exp=0", div_zero); end
    launch(32'h80000000, 32'hFFFFFFFF, 1'b0);
    wait_done(cyc);
    checks++; if (cyc != 34) begin failures++; $display("FAIL ext2_latency got=%0d exp=34", cyc); end
    checks++; if (quotient !== 32'd0) begin failures++; $display("FAIL ext2_q got=%h exp=0", quotient); end
    checks++; if (remainder !== 32'h80000000) begin failures++; $display("FAIL ext2_r got=%h exp=80000000", remainder); end
  endtask

  task automatic test_ignore_start;
    launch(32'd100, 32'd7, 1'b0);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 10 || n == 34) begin
        start = 1'b1; dividend = 32'd9; divisor = 32'd3;
      end
      if (n == 34) begin
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL ign_done got=%b exp=1", done); end
        checks++; if (quotient !== 32'd14) begin failures++; $display("FAIL ign_q got=%h exp=%h", quotient, 32'd14); end
        checks++; if (remainder !== 32'd2) begin failures++; $display("FAIL ign_r got=%h exp=%h", remainder, 32'd2); end
      end
      if (n >= 36) begin
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ign_no_queue cyc=%0d got=%b exp=0", n, busy); end
        checks++; if (quotient !== 32'd14) begin failures++; $display("FAIL ign_hold cyc=%0d got=%h exp=%h", n, quotient, 32'd14); end
      end
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    launch(32'd100, 32'd7, 1'b0);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b exp=0", done); end
    checks++; if (quotient !== '0) begin failures++; $display("FAIL rstmid_q got=%h exp=0", quotient); end
    checks++; if (remainder !== '0) begin failures++; $display("FAIL rstmid_r got=%h exp=0", remainder); end
    checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL rstmid_dz got=%b exp=0", div_zero); end
    @(negedge clk);
    rst_n = 1'b1;
    launch(32'd9, 32'd3, 1'b0);
    wait_done(cyc);
    checks++; if (cyc != 34) begin failures++; $display("FAIL rstmid_latency got=%0d exp=34", cyc); end
    checks++; if (quotient !== 32'd3) begin failures++; $display("FAIL rstmid_q2 got=%h exp=3", quotient); end
    checks++; if (remainder !== 32'd0) begin failures++; $display("FAIL rstmid_r2 got=%h exp=0", remainder); end
  endtask

`ifdef DIVIDER_SIGNED_EN
  task automatic test_signed;
    int cyc;
    launch(32'hFFFFFFF9, 32'd2, 1'b1);
    wait_done(cyc);
    checks++; if (cyc != 34) begin failures++; $display("FAIL sgn1_latency got=%0d exp=34", cyc); end
    checks++; if (quotient !== 32'hFFFFFFFD) begin failures++; $display("FAIL sgn1_q got=%h exp=fffffffd", quotient); end
    checks++; if (remainder !== 32'hFFFFFFFF) begin failures++; $display("FAIL sgn1_r got=%h exp=ffffffff", remainder); end
    launch(32'h80000000, 32'hFFFFFFFF, 1'b1);
    wait_done(cyc);
    checks++; if (cyc != 34) begin failures++; $display("FAIL sgn2_latency got=%0d exp=34", cyc); end
    checks++; if (quotient !== 32'h80000000) begin failures++; $display("FAIL sgn2_q got=%h exp=80000000", quotient); end
    checks++; if (remainder !== 32'd0) begin failures++; $display("FAIL sgn2_r got=%h exp=0", remainder); end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_div_zero;
    test_extremes;
    test_ignore_start;
    test_reset_mid;
`ifdef DIVIDER_SIGNED_EN
    test_signed;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
